// File: rtl/axi_burst_memory_slave_if.sv
// AXI4 burst channel bundle (AW, W, B, AR, R) between a burst master and
// axi_burst_memory_slave. The slave modport is the memory side; the master
// modport is the requester side.
interface axi_burst_memory_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // Write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    input  rready,
    output awready, wready,
    output bid, bresp, bvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    output rready,
    input  awready, wready,
    input  bid, bresp, bvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_memory_slave.sv
// AXI4 INCR burst responder backed by a word-addressed RAM.
// Write and read channels are served by two independent FSMs that share one
// RAM (one write port, one registered read port; a same-cycle read of a word
// being written returns the old contents).
// Optional build macro AXI_MEM_SLAVE_RANDOM_STALL_EN: a 16-bit LFSR throttles
// wready and inserts bubbles between read beats without changing data,
// ordering or responses.
module axi_burst_memory_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                      clk,
  input  logic                      resetn,
  axi_burst_memory_slave_if.slave   bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  // ---------------------------------------------------------------------
  // Stall source
  // ---------------------------------------------------------------------
  logic w_stall;
  logic r_bubble;

`ifdef AXI_MEM_SLAVE_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running maximal-length LFSR (x^16+x^14+x^13+x^11+1), reseeded on reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign w_stall  = lfsr_q[0];
  assign r_bubble = lfsr_q[1];
`else
  assign w_stall  = 1'b0;
  assign r_bubble = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------
  w_state_t              w_state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   wid_q;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [7:0]            wlen_q;
  logic [7:0]            wcnt_q;
  logic                  werr_q;

  logic                  wready_d;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  w_in_range;
  logic                  w_len_hit;
  logic                  w_end;
  logic                  w_beat_err;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;

  assign wready_d   = wready_q & ~w_stall;
  assign aw_hs      = bus.awvalid & awready_q;
  assign w_hs       = bus.wvalid & wready_d;
  assign w_in_range = (widx_q < DEPTH_A);
  assign w_len_hit  = (wcnt_q == wlen_q);
  // Either the beat count or wlast closes the burst; disagreement is an error.
  assign w_end      = w_len_hit | bus.wlast;
  assign w_beat_err = ~w_in_range | (w_len_hit != bus.wlast);
  assign mem_we     = w_hs & w_in_range;
  assign mem_waddr  = widx_q[MEM_AW-1:0];

  // Write FSM: accept AW, absorb W beats into RAM, then hold B until taken
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            wid_q     <= bus.awid;
            widx_q    <= bus.awaddr >> SHIFT;
            wlen_q    <= bus.awlen;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            widx_q <= widx_q + ADDR_WIDTH'(1);
            wcnt_q <= wcnt_q + 8'd1;
            if (w_end) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= wid_q;
              bresp_q   <= (werr_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              werr_q    <= 1'b0;
              w_state_q <= W_RESP;
            end else begin
              werr_q <= werr_q | w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read side state
  // ---------------------------------------------------------------------
  r_state_t              r_state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] ridx_q;
  logic [7:0]            rleft_q;
  logic                  rpend_q;

  logic                  ar_hs;
  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] ar_idx_d;
  logic [ADDR_WIDTH-1:0] rnext_idx_d;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_idx_d;
  logic [MEM_AW-1:0]     rd_addr;

  assign ar_hs       = bus.arvalid & arready_q;
  assign r_hs        = rvalid_q & bus.rready;
  assign ar_idx_d    = bus.araddr >> SHIFT;
  assign rnext_idx_d = ridx_q + ADDR_WIDTH'(1);
  // Fetch the first beat on AR, and each following beat as the current one is taken.
  assign rd_en       = ar_hs | (r_hs & ~rlast_q);
  assign rd_idx_d    = ar_hs ? ar_idx_d : rnext_idx_d;
  assign rd_addr     = rd_idx_d[MEM_AW-1:0];

  // RAM: byte-enabled write port plus registered read port, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[mem_waddr][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      ram_rd_q <= mem_q[rd_addr];
    end
  end

  // Read FSM: accept AR, stream beats with per-beat range check, release on last beat
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      ridx_q    <= '0;
      rleft_q   <= '0;
      rpend_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rid_q     <= bus.arid;
            ridx_q    <= ar_idx_d;
            rleft_q   <= bus.arlen;
            rvalid_q  <= 1'b1;
            rlast_q   <= (bus.arlen == 8'd0);
            rresp_q   <= (ar_idx_d < DEPTH_A) ? RESP_OKAY : RESP_SLVERR;
            rpend_q   <= 1'b0;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rpend_q) begin
            // Bubble over: the already-fetched beat goes out now.
            rvalid_q <= 1'b1;
            rpend_q  <= 1'b0;
          end else if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= RESP_OKAY;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              ridx_q  <= rnext_idx_d;
              rleft_q <= rleft_q - 8'd1;
              rlast_q <= (rleft_q == 8'd1);
              rresp_q <= (rnext_idx_d < DEPTH_A) ? RESP_OKAY : RESP_SLVERR;
              if (r_bubble) begin
                rvalid_q <= 1'b0;
                rpend_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.awready = awready_q;
  assign bus.wready  = wready_d;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  // Out-of-range beats and idle cycles read as zero; the RAM read register
  // itself is not reset.
  assign bus.rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_rd_q : '0;

endmodule

// File: tb/tb_axi_burst_memory_slave.sv
// Scoreboard bench for axi_burst_memory_slave: a driver issues AXI bursts and
// pushes the responses a word-array memory model predicts; independent B and R
// monitors pop and compare whenever the DUT hands over a response.
module tb_axi_burst_memory_slave;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 256;
  localparam int LIMIT = 3000;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  axi_burst_memory_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_burst_memory_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wd [256];
  logic [3:0]    ws [256];
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  int vectors = 0;
  int miscompares = 0;
  int b_done = 0;
  int r_done = 0;
  int rmode = 0;
  int pat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out after %0d cycles at %0t", name, LIMIT, $time);
  endtask

  // Wait (sampling at negedge) until the selected ready is seen high.
  task automatic wait_ready(input int which, input string name);
    int  n  = 0;
    bit  ok = 0;
    while (!ok && n < LIMIT) begin
      @(negedge clk);
      n++;
      case (which)
        0:       ok = bus.awready;
        1:       ok = bus.wready;
        default: ok = bus.arready;
      endcase
    end
    if (!ok) timeout_fail(name);
  endtask

  function automatic void model_beat(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
    if (idx < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  function automatic logic [49:0] all_outputs();
    return {bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp, bus.arready,
            bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast};
  endfunction

  // Write burst; wlast goes out on beat last_at, abort_after>=0 pulls reset after that beat.
  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input int last_at, input int abort_after);
    int  idx0     = int'(addr >> 2);
    int  end_beat = (last_at < len) ? last_at : len;
    bit  err      = (last_at != len);
    int  target   = b_done + 1;
    int  n        = 0;
    for (int i = 0; i <= end_beat; i++) if (idx0 + i >= DEPTH) err = 1;
    if (abort_after < 0) b_q.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
    $display("WRITE id=%0h addr=0x%0h len=%0d last_at=%0d abort=%0d", id, addr, len, last_at, abort_after);
    @(posedge clk); #1;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awvalid = 1'b1;
    wait_ready(0, "aw_handshake");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= end_beat; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at);
      wait_ready(1, "w_handshake");
      @(posedge clk); #1;
      model_beat(idx0 + i, wd[i], ws[i]);
      if (i == abort_after) begin
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("outputs_after_midburst_reset", 64'(all_outputs()), 64'd0);
        resetn = 1'b1;
        return;
      end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_one_cycle_after_last_beat", 64'(bus.bvalid), 64'd1);
    while (b_done < target && n < LIMIT) begin @(negedge clk); n++; end
    if (b_done < target) timeout_fail("b_response");
  endtask

  // Read burst; mode 0 holds rready, 1 randomises it, 2 uses a 1,0,0,1 repeating pattern.
  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input int mode);
    int idx0   = int'(addr >> 2);
    int target = r_done + 1;
    int n      = 0;
    for (int i = 0; i <= len; i++) begin
      int idx = idx0 + i;
      r_q.push_back('{id: id,
                      data: (idx < DEPTH) ? ref_mem[idx] : '0,
                      resp: (idx < DEPTH) ? 2'b00 : 2'b10,
                      last: (i == len)});
    end
    $display("READ  id=%0h addr=0x%0h len=%0d mode=%0d", id, addr, len, mode);
    @(posedge clk); #1;
    pat = 0; rmode = mode;
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arvalid = 1'b1;
    wait_ready(2, "ar_handshake");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check("rvalid_one_cycle_after_ar", 64'(bus.rvalid), 64'd1);
`ifndef AXI_MEM_SLAVE_RANDOM_STALL_EN
    if (mode == 0) begin
      for (int i = 0; i <= len; i++) begin
        @(negedge clk);
        check("r_back_to_back", 64'(bus.rvalid), 64'd1);
      end
    end
`endif
    while (r_done < target && n < LIMIT) begin @(negedge clk); n++; end
    if (r_done < target) timeout_fail("r_burst_complete");
    rmode = 0;
  endtask

  // Ready generators for the response channels
  initial begin
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      pat++;
      case (rmode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = 1'($urandom_range(0, 1));
        default: bus.rready = !(((pat % 4) == 1) || ((pat % 4) == 2));
      endcase
      bus.bready = ($urandom_range(0, 3) != 0);
    end
  end

  // B monitor
  initial begin : mon_b
    b_exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.bvalid && bus.bready) begin
        if (b_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_b: got bid=%0h bresp=%0h, expected no response", bus.bid, bus.bresp);
        end else begin
          e = b_q.pop_front();
          check("bid", 64'(bus.bid), 64'(e.id));
          check("bresp", 64'(bus.bresp), 64'(e.resp));
        end
        b_done++;
      end
    end
  end

  // R monitor: compares handed-over beats and checks stability across stalls
  initial begin : mon_r
    r_exp_t      e;
    bit          held;
    logic [38:0] held_v;
    held = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        held = 0;
      end else if (bus.rvalid && !bus.rready) begin
        if (held) check("r_stall_stable", 64'({bus.rid, bus.rdata, bus.rresp, bus.rlast}), 64'(held_v));
        held_v = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
        held = 1;
      end else if (bus.rvalid && bus.rready) begin
        if (r_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_r: got rdata=0x%0h, expected no beat", bus.rdata);
        end else begin
          e = r_q.pop_front();
          check("rid", 64'(bus.rid), 64'(e.id));
          check("rdata", 64'(bus.rdata), 64'(e.data));
          check("rresp", 64'(bus.rresp), 64'(e.resp));
          check("rlast", 64'(bus.rlast), 64'(e.last));
          if (e.last) r_done++;
        end
        held = 0;
      end else begin
        held = 0;
      end
    end
  end

  // Main stimulus
  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("outputs_in_reset", 64'(all_outputs()), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("awready_after_reset", 64'(bus.awready), 64'd1);
    check("arready_after_reset", 64'(bus.arready), 64'd1);

    // Fill the whole RAM so every later read has a defined model value
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(4'h0, 32'h0, 255, 255, -1);

    // Basic 8-beat write then read back with rready held
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h0A + i; ws[i] = 4'hF; end
    write_burst(4'hA, 32'h0, 7, 7, -1);
    read_burst(4'hA, 32'h0, 7, 0);

    // Partial strobe merge into word 0
    wd[0] = 32'hDEADBEEF; ws[0] = 4'b0011;
    write_burst(4'h3, 32'h0, 0, 0, -1);
    read_burst(4'h3, 32'h0, 0, 0);

    // rready stall pattern
    read_burst(4'h5, 32'h0, 7, 2);

    // Burst running past the end of the RAM
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(4'h7, 32'((DEPTH - 2) * 4), 3, 3, -1);
    read_burst(4'h7, 32'((DEPTH - 2) * 4), 3, 1);

    // Early wlast ends the burst with an error
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(4'h9, 32'h40, 3, 1, -1);
    read_burst(4'h9, 32'h40, 3, 0);

    // Reset after the third write beat; earlier beats stay in RAM
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h5500 + i; ws[i] = 4'hF; end
    write_burst(4'hC, 32'h0, 7, 7, 2);
    read_burst(4'hC, 32'h0, 7, 1);
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(4'hD, 32'h8, 1, 1, -1);

    // Randomised traffic
    for (int t = 0; t < 30; t++) begin
      logic [AW-1:0] a;
      int            len;
      a   = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        write_burst(4'($urandom), a, len, len, -1);
      end else begin
        read_burst(4'($urandom), a, len, 1);
      end
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(b_q.size() + r_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_burst_memory_slave.md
Name: axi_burst_memory_slave

Overview:
AXI4 burst responder with internal word-addressed RAM. It is the far end of AXI_memory_master_burst and replaces the behavioural slave model in the master bench. Write and read channels run independently, and it supports INCR bursts of up to 256 beats. IDs are echoed on B and R.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width, a power of two no less than 8; full-width beats only
ID_WIDTH, 4, transaction ID width
MEM_DEPTH, 256, RAM depth in DATA_WIDTH words

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
awid  in  ID_WIDTH  write burst ID
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  beats minus 1
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write beat data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  echoed awid
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  ID_WIDTH  read burst ID
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  beats minus 1
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  echoed arid
rdata  out  DATA_WIDTH  read beat data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  last read beat
rvalid  out  1  R valid

Behaviour:
- Reset, while resetn is sampled low: all outputs are 0, both FSMs go idle, and the error flags clear. RAM contents are kept, not cleared. A reset mid-burst abandons that burst.
- Word index = address >> log2(DATA_WIDTH/8); the low address bits are ignored. A beat is out of range when its index >= MEM_DEPTH. There is no wrap and no 4KB-boundary check; INCR only, index +1 per beat.
- Write FSM, W_IDLE (awready=1 from the first cycle after reset):
  - On the AW handshake: latch awid, index and awlen. Next cycle awready=0 and wready=1, state W_DATA.
- Write FSM, W_DATA:
  - On each W handshake: write the bytes enabled by wstrb to RAM[index] if in range, otherwise set err. Then increment index and beat count.
  - The burst ends on the beat where count==len or wlast=1. A mismatch between count and wlast sets err.
  - At burst end: next cycle wready=0, bvalid=1, bid=latched ID, bresp=err?10:00, state W_RESP.
- Write FSM, W_RESP: hold bvalid, bid and bresp until bready. After the handshake: bvalid=0, awready=1, state W_IDLE.
- Read FSM, R_IDLE (arready=1): on the AR handshake, latch arid, index and arlen; arready=0, state R_DATA.
- Read FSM, R_DATA:
  - rvalid rises 1 cycle after the AR handshake, with rdata=RAM[index] (or 0 and rresp=10 if out of range), rid=latched ID, rlast=(beats left==0).
  - On rvalid&&rready: present the next beat the following cycle, so a held rready gives 1 beat/cycle.
  - After the last beat handshake: rvalid=0, rlast=0, arready=1.
- While rvalid&&!rready: rdata, rresp, rlast and rid stay stable.
- A same-cycle write and read to one word: the read returns the old data.

Optional Feature:
Macro AXI_MEM_SLAVE_RANDOM_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, advanced every cycle, reloaded on reset) gates both data channels.
  - wready is driven low in W_DATA on cycles where lfsr[0]=1.
  - A bubble is inserted before the next beat when lfsr[1]=1.
  - Data, ordering and responses are unchanged.
- Undefined: wready is held high through W_DATA and R beats are back-to-back.

Test Plan:
- Write awid=A, awaddr=0, awlen=7, data 0x0A..0x11, wstrb=F, wlast on beat 8, bready=1 -> bvalid 1 cycle after beat 8, bid=A, bresp=00, RAM[0..7]=0x0A..0x11.
- Then read arid=A, araddr=0, arlen=7, rready=1 -> 8 consecutive beats 0x0A..0x11, rvalid starting 1 cycle after AR, rlast on beat 8 only, rid=A, rresp=00.
- Write 0xDEADBEEF at 0x0 with wstrb=0011 over 0x0000000A, then read -> 0x0000BEEF.
- Read with rready pattern 1,0,0,1,1... -> rdata held during stalls, no beat lost or duplicated, 8 beats total.
- awaddr=(MEM_DEPTH-2)*4, awlen=3 -> bresp=10, only 2 words written. Read of the same range -> rresp=10 and rdata=0 on beats 3-4.
- resetn low for 1 cycle after write beat 3 -> all outputs 0 next cycle, RAM[0..2] retained, next AW accepted.
